// File: rtl/brg_param_pkg.sv
// brg_param_pkg: shared SPART constants and divisor helper for the baud-rate generator
package brg_param_pkg;
  localparam int SPART_DATA_W = 8;
  localparam int SPART_OSR = 16;
  function automatic int calc_div(int clk_hz, int baud);
    return (clk_hz + baud * SPART_OSR / 2) / (baud * SPART_OSR) - 1;
  endfunction
  localparam int DIV_25M_4800 = calc_div(25_000_000, 4800);
  localparam int DIV_25M_9600 = calc_div(25_000_000, 9600);
  localparam int DIV_25M_19200 = calc_div(25_000_000, 19200);
  localparam int DIV_25M_38400 = calc_div(25_000_000, 38400);
  localparam int DIV_50M_4800 = calc_div(50_000_000, 4800);
  localparam int DIV_50M_9600 = calc_div(50_000_000, 9600);
  localparam int DIV_50M_19200 = calc_div(50_000_000, 19200);
  localparam int DIV_50M_38400 = calc_div(50_000_000, 38400);
  localparam int DIV_100M_4800 = calc_div(100_000_000, 4800);
  localparam int DIV_100M_9600 = calc_div(100_000_000, 9600);
  localparam int DIV_100M_19200 = calc_div(100_000_000, 19200);
  localparam int DIV_100M_38400 = calc_div(100_000_000, 38400);
endpackage

// File: rtl/brg_param_if.sv
// brg_param_if: control/load inputs and tick outputs of the baud-rate generator
interface brg_param_if import brg_param_pkg::*; ();
  logic brg_en;
  logic load_low;
  logic load_high;
  logic [SPART_DATA_W-1:0] data_in;
  logic sample_tick;
  logic baud_tick;
  logic brg_ready;
  logic pending;
  modport master(output brg_en, load_low, load_high, data_in, input sample_tick, baud_tick, brg_ready, pending);
  modport slave(input brg_en, load_low, load_high, data_in, output sample_tick, baud_tick, brg_ready, pending);
endinterface

// File: rtl/brg_param_div_cnt.sv
// brg_div_cnt: reloadable down counter with enable and terminal-count flag
module brg_div_cnt #(
  parameter int W = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;
  assign o_tc = (r_cnt == '0);
  // reload takes priority over counting down
  always_ff @(posedge clk)
    if (rst) r_cnt <= RST_VAL;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en) r_cnt <= r_cnt - 1'b1;
endmodule

// File: rtl/brg_param.sv
// brg_param: baud-rate generator with double-buffered divisor and oversampled ticks
module brg_param import brg_param_pkg::*; #(
  parameter int DIV_W = 16,
  parameter int OSR = SPART_OSR,
  parameter logic [DIV_W-1:0] RESET_DIV = DIV_W'(DIV_50M_19200)
) (
  input logic clk,
  input logic rst,
  brg_param_if.slave bus
);
  localparam int OS_W = $clog2(OSR);
  logic [DIV_W-1:0] r_shadow, r_active, w_reload;
  logic r_wrote_lo, r_wrote_hi, r_sample, r_baud, r_ready;
  logic w_pending, w_run, w_div_tc, w_os_tc, w_tc, w_commit;
  assign w_pending = r_wrote_lo & r_wrote_hi;
  assign w_run = bus.brg_en & (|r_active);
  assign w_tc = w_run & w_div_tc;
  // a zero divisor never reaches terminal count, so a pending shadow commits immediately
  assign w_commit = w_pending & (w_tc | ~|r_active);
  assign w_reload = w_commit ? r_shadow : r_active;
  assign bus.sample_tick = r_sample;
  assign bus.baud_tick = r_baud;
  assign bus.brg_ready = r_ready;
  assign bus.pending = w_pending;
  brg_div_cnt #(.W(DIV_W), .RST_VAL(RESET_DIV)) u_div (
    .clk(clk), .rst(rst), .i_en(w_run), .i_load(w_tc | w_commit), .i_load_val(w_reload), .o_tc(w_div_tc)
  );
  brg_div_cnt #(.W(OS_W), .RST_VAL(OS_W'(OSR - 1))) u_os (
    .clk(clk), .rst(rst), .i_en(w_tc), .i_load(w_tc & w_os_tc), .i_load_val(OS_W'(OSR - 1)), .o_tc(w_os_tc)
  );
  // shadow loads, commit into the active divisor, and registered tick outputs
  always_ff @(posedge clk)
    if (rst) begin
      r_shadow <= RESET_DIV;
      r_active <= RESET_DIV;
      r_wrote_lo <= 1'b0;
      r_wrote_hi <= 1'b0;
      r_sample <= 1'b0;
      r_baud <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      if (bus.load_low) r_shadow[7:0] <= bus.data_in;
      else if (bus.load_high) r_shadow[DIV_W-1:8] <= bus.data_in[DIV_W-9:0];
      r_wrote_lo <= (r_wrote_lo & ~w_commit) | bus.load_low;
      r_wrote_hi <= (r_wrote_hi & ~w_commit) | (bus.load_high & ~bus.load_low);
      if (w_commit) r_active <= r_shadow;
      r_sample <= w_tc;
      r_baud <= w_tc & w_os_tc;
      r_ready <= w_run;
    end
endmodule

// File: tb/tb_brg_param.sv
// tb_brg_param: directed and random checks of brg_param against a cycle-count reference model
module tb_brg_param;
  localparam int OSR = 4;
  localparam int RD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  brg_param_if bus();
  brg_param #(.DIV_W(16), .OSR(OSR), .RESET_DIV(16'd4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int m_active, m_shadow, m_elapsed, m_n;
  bit m_lo, m_hi, m_sample, m_baud, m_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // period = active+1 enabled cycles since the last reload; baud on every OSR-th sample tick
  task automatic model(input bit r, input bit en, input bit ll, input bit lh, input bit [7:0] d);
    bit pend, run, tc, commit;
    if (r) begin
      m_active = RD; m_shadow = RD; m_elapsed = 0; m_n = 0;
      m_lo = 0; m_hi = 0; m_sample = 0; m_baud = 0; m_ready = 0;
    end else begin
      pend = m_lo && m_hi;
      run = en && m_active != 0;
      tc = run && m_elapsed == m_active;
      commit = pend && (tc || m_active == 0);
      m_ready = run;
      m_sample = tc;
      m_baud = tc && ((m_n + 1) % OSR == 0);
      if (tc) m_n++;
      if (run) m_elapsed = tc ? 0 : m_elapsed + 1;
      if (commit) begin m_active = m_shadow; m_elapsed = 0; m_lo = 0; m_hi = 0; end
      if (ll) begin m_shadow = (m_shadow & 32'hFF00) | int'(d); m_lo = 1; end
      else if (lh) begin m_shadow = (m_shadow & 32'hFF) | (int'(d) << 8); m_hi = 1; end
    end
  endtask

  task automatic step(input bit r, input bit en, input bit ll, input bit lh, input bit [7:0] d);
    rst = r; bus.brg_en = en; bus.load_low = ll; bus.load_high = lh; bus.data_in = d;
    @(posedge clk);
    model(r, en, ll, lh, d);
    #1;
    chk("sample_tick", bus.sample_tick, m_sample);
    chk("baud_tick", bus.baud_tick, m_baud);
    chk("brg_ready", bus.brg_ready, m_ready);
    chk("pending", bus.pending, m_lo && m_hi);
  endtask

  task automatic gap(input string tag, input int exp);
    int n = 0;
    do begin step(0, 1, 0, 0, 8'h00); n++; end while (bus.sample_tick !== 1'b1 && n < 200);
    chk(tag, n, exp);
  endtask

  initial begin
    int n;
    bit r, en, ll, lh;
    bit [7:0] d;
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    n = 0;
    do begin step(0, 1, 0, 0, 8'h00); n++; end while (bus.baud_tick !== 1'b1 && n < 200);
    chk("first_baud", n, 20);
    gap("period_5", 5);
    step(0, 1, 1, 0, 8'h09);
    step(0, 1, 0, 1, 8'h00);
    chk("pending_set", bus.pending, 1);
    gap("old_period_done", 3);
    gap("period_10a", 10);
    gap("period_10b", 10);
    step(0, 1, 1, 1, 8'h33);
    chk("both_loads_pending", bus.pending, 0);
    step(0, 1, 0, 1, 8'h00);
    gap("before_51", 8);
    gap("period_52", 52);
    step(0, 1, 1, 0, 8'h00);
    step(0, 1, 0, 1, 8'h00);
    gap("last_52", 50);
    repeat (10) step(0, 1, 0, 0, 8'h00);
    chk("ready_zero_div", bus.brg_ready, 0);
    step(0, 1, 1, 0, 8'h03);
    step(0, 1, 0, 1, 8'h00);
    gap("zero_recover", 5);
    gap("period_4", 4);
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    repeat (7) step(0, 0, 0, 0, 8'h00);
    chk("ready_disabled", bus.brg_ready, 0);
    gap("resume_remaining", 2);
    gap("period_4_after_en", 4);
    step(0, 1, 1, 0, 8'h07);
    step(0, 1, 0, 1, 8'h00);
    chk("pending_before_rst", bus.pending, 1);
    step(1, 1, 0, 0, 8'h00);
    chk("rst_pending", bus.pending, 0);
    chk("rst_sample", bus.sample_tick, 0);
    chk("rst_ready", bus.brg_ready, 0);
    gap("after_rst", 5);
    gap("reset_div_period", 5);
    repeat (600) begin
      r = ($urandom % 150) == 0;
      en = ($urandom % 8) != 0;
      ll = ($urandom % 12) == 0;
      lh = ($urandom % 12) == 0;
      d = ll ? 8'($urandom_range(0, 9)) : 8'h00;
      step(r, en, ll, lh, d);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
